// File: rtl/ascii_int32_tokenizer.sv
// ascii_int32_tokenizer
// Streaming decimal tokenizer. It takes one ASCII byte per cycle and emits one
// signed 32-bit integer for each decimal token. It also reports the per-frame
// token count, the end of each frame, and sticky error flags.
//
// Optional feature macro: SATURATE_EN
//   defined   : an out-of-range token is clamped to 32'h7FFFFFFF / 32'h80000000,
//               then emitted and counted
//   undefined : an out-of-range token is dropped
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   clr          synchronous soft clear (has priority over an accepted byte)
//   in_data      ASCII byte
//   in_valid     byte valid; accepted when in_valid && in_ready
//   in_ready     0 while rst is asserted, otherwise 1
//   data_out     signed token value; holds the last value between pulses
//   data_valid   one-cycle pulse per emitted token
//   num_count    tokens emitted in the current frame
//   frame_done   one-cycle pulse after the terminator has been processed
//   err_invalid  sticky: illegal char, lone sign or count limit hit in frame
//   err_overflow sticky: token out of int32 range in frame
//
// state  | meaning
// IDLE   | between tokens
// SIGN   | sign seen, no digit yet
// DIGITS | accumulating digits of a token
// SKIP   | discarding bytes up to the next delimiter/terminator after an error
module ascii_int32_tokenizer #(
   parameter logic [7:0] TERM_CHAR = 8'h0A,
   parameter int         MAX_COUNT = 2047
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] data_out,
   output logic        data_valid,
   output logic [10:0] num_count,
   output logic        frame_done,
   output logic        err_invalid,
   output logic        err_overflow
);

   typedef enum logic [1:0] {IDLE, SIGN, DIGITS, SKIP} state_t;

   state_t      state;
   logic [33:0] acc;
   logic        neg;
   logic        ovf;

   logic        is_digit, is_sign, is_delim, is_term;
   logic [35:0] prod;
   logic [35:0] limit;
   logic        prod_ovf;
   logic [10:0] cnt_base;
   logic        cnt_full;
   logic        tok_emit;
   logic [31:0] tok_val;

   assign in_ready = ~rst;

   always_comb begin
      is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
      is_sign  = (in_data == 8'h2D) || (in_data == 8'h2B);
      is_delim = (in_data == 8'h20) || (in_data == 8'h2C) ||
                 (in_data == 8'h09) || (in_data == 8'h0D);
      is_term  = (in_data == TERM_CHAR);

      // 36 bits so that acc*10+9 cannot wrap before the range compare.
      prod     = {2'b00, acc} * 36'd10 + {32'd0, in_data[3:0]};
      limit    = neg ? 36'h0_8000_0000 : 36'h0_7FFF_FFFF;
      prod_ovf = prod > limit;

      // The count is cleared on the cycle after frame_done. A byte accepted in
      // that cycle already belongs to the new frame, so it counts from zero.
      cnt_base = frame_done ? 11'd0 : num_count;
      cnt_full = (cnt_base == 11'(MAX_COUNT));

`ifdef SATURATE_EN
      tok_emit = 1'b1;
      if (ovf)
         tok_val = neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
      else
         tok_val = neg ? -acc[31:0] : acc[31:0];
`else
      tok_emit = ~ovf;
      tok_val  = neg ? -acc[31:0] : acc[31:0];
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         acc          <= '0;
         neg          <= 1'b0;
         ovf          <= 1'b0;
         data_out     <= '0;
         data_valid   <= 1'b0;
         num_count    <= '0;
         frame_done   <= 1'b0;
         err_invalid  <= 1'b0;
         err_overflow <= 1'b0;
      end else if (clr) begin
         state        <= IDLE;
         acc          <= '0;
         neg          <= 1'b0;
         ovf          <= 1'b0;
         data_valid   <= 1'b0;
         num_count    <= '0;
         frame_done   <= 1'b0;
         err_invalid  <= 1'b0;
         err_overflow <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         frame_done <= 1'b0;
         if (frame_done) begin
            num_count    <= '0;
            err_invalid  <= 1'b0;
            err_overflow <= 1'b0;
         end
         if (in_valid) begin
            unique case (state)
               IDLE: begin
                  if (is_digit) begin
                     state <= DIGITS;
                     acc   <= {30'd0, in_data[3:0]};
                     neg   <= 1'b0;
                     ovf   <= 1'b0;
                  end else if (is_sign) begin
                     state <= SIGN;
                     neg   <= (in_data == 8'h2D);
                     ovf   <= 1'b0;
                  end else if (is_term) begin
                     frame_done <= 1'b1;
                  end else if (!is_delim) begin
                     err_invalid <= 1'b1;
                     state       <= SKIP;
                  end
               end
               SIGN: begin
                  if (is_digit) begin
                     state <= DIGITS;
                     acc   <= {30'd0, in_data[3:0]};
                  end else begin
                     err_invalid <= 1'b1;
                     if (is_delim) begin
                        state <= IDLE;
                     end else if (is_term) begin
                        state      <= IDLE;
                        frame_done <= 1'b1;
                     end else begin
                        state <= SKIP;
                     end
                  end
               end
               DIGITS: begin
                  if (is_digit) begin
                     if (!ovf) begin
                        if (prod_ovf) begin
                           ovf          <= 1'b1;
                           err_overflow <= 1'b1;
                        end else begin
                           acc <= prod[33:0];
                        end
                     end
                  end else if (is_delim || is_term) begin
                     state <= IDLE;
                     acc   <= '0;
                     if (is_term)
                        frame_done <= 1'b1;
                     if (tok_emit) begin
                        if (cnt_full) begin
                           err_invalid <= 1'b1;
                        end else begin
                           data_valid <= 1'b1;
                           data_out   <= tok_val;
                           num_count  <= cnt_base + 11'd1;
                        end
                     end
                  end else begin
                     err_invalid <= 1'b1;
                     state       <= SKIP;
                     acc         <= '0;
                  end
               end
               SKIP: begin
                  if (is_delim) begin
                     state <= IDLE;
                  end else if (is_term) begin
                     state      <= IDLE;
                     frame_done <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ascii_int32_tokenizer.sv
module tb_ascii_int32_tokenizer;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] data_out;
   logic        data_valid;
   logic [10:0] num_count;
   logic        frame_done;
   logic        err_invalid;
   logic        err_overflow;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] v;
      logic [10:0] c;
   } tok_t;

   typedef struct {
      logic [10:0] c;
      logic        ei;
      logic        eo;
   } frm_t;

   tok_t tok_q[$];
   frm_t frm_q[$];

   ascii_int32_tokenizer dut (
      .clk          (clk),
      .rst          (rst),
      .clr          (clr),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .data_out     (data_out),
      .data_valid   (data_valid),
      .num_count    (num_count),
      .frame_done   (frame_done),
      .err_invalid  (err_invalid),
      .err_overflow (err_overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic exp_tok(input logic [31:0] v, input logic [10:0] c);
      tok_t t;
      t.v = v;
      t.c = c;
      tok_q.push_back(t);
   endtask

   task automatic exp_frm(input logic [10:0] c, input logic ei, input logic eo);
      frm_t f;
      f.c  = c;
      f.ei = ei;
      f.eo = eo;
      frm_q.push_back(f);
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (data_valid) begin
         if (tok_q.size() == 0) begin
            chk("unexpected_data_valid", data_out, 32'hDEAD_BEEF);
         end else begin
            tok_t t;
            t = tok_q.pop_front();
            chk("data_out", data_out, t.v);
            chk("num_count_at_token", {21'd0, num_count}, {21'd0, t.c});
         end
      end
      if (frame_done) begin
         if (frm_q.size() == 0) begin
            chk("unexpected_frame_done", {21'd0, num_count}, 32'hDEAD_BEEF);
         end else begin
            frm_t f;
            f = frm_q.pop_front();
            chk("frame_count", {21'd0, num_count}, {21'd0, f.c});
            chk("frame_err_invalid", {31'd0, err_invalid}, {31'd0, f.ei});
            chk("frame_err_overflow", {31'd0, err_overflow}, {31'd0, f.eo});
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      in_data  = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 8'h61;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_str(input string s, input int gap);
      for (int i = 0; i < s.len(); i++)
         send_byte(s[i], gap);
   endtask

   initial begin
      rst      = 1'b1;
      clr      = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      #2;
      chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
      chk("reset_data_out", data_out, 32'd0);
      chk("reset_num_count", {21'd0, num_count}, 32'd0);
      chk("reset_pulses", {30'd0, data_valid, frame_done}, 32'd0);
      chk("reset_errs", {30'd0, err_invalid, err_overflow}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;

      // Basic mixed delimiters and a negative token.
      exp_tok(32'd12, 11'd1);
      exp_tok(32'hFFFF_FFDE, 11'd2);
      exp_tok(32'd5, 11'd3);
      exp_frm(11'd3, 1'b0, 1'b0);
      send_str("12 -34,5\n", 0);

      // int32 extremes.
      exp_tok(32'h8000_0000, 11'd1);
      exp_tok(32'h7FFF_FFFF, 11'd2);
      exp_frm(11'd2, 1'b0, 1'b0);
      send_str("-2147483648\t2147483647\r\n", 0);

      // Positive and negative overflow.
`ifdef SATURATE_EN
      exp_tok(32'h7FFF_FFFF, 11'd1);
      exp_frm(11'd1, 1'b0, 1'b1);
      exp_tok(32'h8000_0000, 11'd1);
      exp_frm(11'd1, 1'b0, 1'b1);
`else
      exp_frm(11'd0, 1'b0, 1'b1);
      exp_frm(11'd0, 1'b0, 1'b1);
`endif
      send_str("2147483648\n", 0);
      send_str("-2147483649\n", 0);

      // Illegal char inside a token, lone sign, then a good token.
      exp_tok(32'd7, 11'd1);
      exp_frm(11'd1, 1'b1, 1'b0);
      send_str("1a2 - 7\n", 0);
      // The next frame starts with the errors cleared.
      exp_tok(32'd3, 11'd1);
      exp_frm(11'd1, 1'b0, 1'b0);
      send_str("3\n", 0);

      // Gapped in_valid, with junk on in_data while it is low.
      exp_tok(32'd99, 11'd1);
      exp_frm(11'd1, 1'b0, 1'b0);
      send_str("99\n", 3);

      // "-0", leading zeros, '+' sign.
      exp_tok(32'd0, 11'd1);
      exp_tok(32'd7, 11'd2);
      exp_tok(32'd5, 11'd3);
      exp_frm(11'd3, 1'b0, 1'b0);
      send_str("-0 007 +5\n", 0);

      // Consecutive terminators.
      exp_frm(11'd0, 1'b0, 1'b0);
      exp_frm(11'd0, 1'b0, 1'b0);
      send_str("\n\n", 0);

      // Reset in the middle of a token.
      send_str("45", 0);
      rst = 1'b1;
      #1;
      chk("midrst_data_out", data_out, 32'd0);
      chk("midrst_num_count", {21'd0, num_count}, 32'd0);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_tok(32'd8, 11'd1);
      exp_frm(11'd1, 1'b0, 1'b0);
      send_str("8\n", 0);

      // clr in the same cycle as a delimiter.
      exp_tok(32'd5, 11'd1);
      send_str("5 6", 0);
      chk("pre_clr_count", {21'd0, num_count}, 32'd1);
      in_data  = 8'h20;
      in_valid = 1'b1;
      clr      = 1'b1;
      @(posedge clk);
      #1;
      clr      = 1'b0;
      in_valid = 1'b0;
      chk("post_clr_count", {21'd0, num_count}, 32'd0);
      chk("post_clr_data_valid", {31'd0, data_valid}, 32'd0);
      exp_frm(11'd0, 1'b0, 1'b0);
      send_str("\n", 0);

      // Count limit: the 2048th token is refused and flagged.
      for (int i = 1; i <= 2047; i++)
         exp_tok(32'd1, 11'(i));
      exp_frm(11'd2047, 1'b1, 1'b0);
      for (int i = 0; i < 2048; i++)
         send_str("1 ", 0);
      send_str("\n", 0);

      for (int i = 0; i < 20 && (tok_q.size() != 0 || frm_q.size() != 0); i++)
         @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      chk("tok_queue_drained", tok_q.size(), 32'd0);
      chk("frame_queue_drained", frm_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
